// File: rtl/myfifo_pkg.sv
// myfifo_pkg: shared widths, FSM states and header magic for the packet FIFO read side.
package myfifo_pkg;
   localparam int DATA_W = 64;
   localparam int USEDW_W = 8;
   localparam logic [15:0] HDR_MAGIC = 16'hA5A5;
   typedef enum logic [1:0] {IDLE, HDR, PKT} state_t;
endpackage

// File: rtl/myfifo_rd_skid.sv
// myfifo_rd_skid: 2-entry valid/ready skid buffer; occupancy is exported for read-credit accounting.
module myfifo_rd_skid #(
   parameter int W = 66
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   input  logic         pop_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic [1:0]   occ_o
);
   logic [W-1:0] mem_q [2];
   logic wr_q, rd_q, pop;
   logic [1:0] occ_q;
   assign valid_o = occ_q != 2'd0;
   assign pop = valid_o & pop_i;
   assign data_o = valid_o ? mem_q[rd_q] : '0;
   assign occ_o = occ_q;
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= push_data_i;
      if (reset) begin
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         occ_q <= 2'd0;
      end else begin
         wr_q  <= wr_q ^ push_i;
         rd_q  <= rd_q ^ pop;
         occ_q <= occ_q + 2'(push_i) - 2'(pop);
      end
   end
endmodule

// File: rtl/myfifo_pkt_reader.sv
// myfifo_pkt_reader: drains whole PKT_WORDS packets from the FIFO read side onto Avalon-ST.
// Defining PKT_HDR_EN prepends a header beat {A5A5, seq, PKT_WORDS, 0000} to every packet.
module myfifo_pkt_reader #(
   parameter int DATA_W    = myfifo_pkg::DATA_W,
   parameter int USEDW_W   = myfifo_pkg::USEDW_W,
   parameter int PKT_WORDS = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_enable,
   input  logic [DATA_W-1:0]  fifo_q,
   input  logic [USEDW_W-1:0] fifo_rdusedw,
   input  logic               fifo_rdfull,
   input  logic               fifo_rdempty,
   output logic               fifo_rdreq,
   output logic [DATA_W-1:0]  src_data,
   output logic               src_valid,
   input  logic               src_ready,
   output logic               src_sop,
   output logic               src_eop,
   output logic [2:0]         src_empty,
   output logic [31:0]        pkt_count,
   output logic               underrun_err
);
   import myfifo_pkg::*;
   localparam logic [USEDW_W:0] PW = (USEDW_W+1)'(PKT_WORDS);
   localparam logic [USEDW_W:0] LAST = (USEDW_W+1)'(PKT_WORDS - 1);
   state_t state_q, state_d;
   logic [USEDW_W:0] req_cnt_q, req_cnt_d, avail;
   logic inflight_q, fl_sop_q, fl_eop_q, xfer, push, push_sop, push_eop;
   logic [1:0] occ, used;
   logic [DATA_W-1:0] hdr_word, push_data;
   logic [DATA_W+1:0] out_bus;
`ifdef PKT_HDR_EN
   localparam state_t FIRST = HDR;
   localparam logic HDR_EN = 1'b1;
   logic [15:0] seq_q;
   always_ff @(posedge clk) seq_q <= reset ? '0 : seq_q + 16'(state_q == HDR);
   assign hdr_word = DATA_W'({HDR_MAGIC, seq_q, 16'(PKT_WORDS), 16'h0000});
`else
   localparam state_t FIRST = PKT;
   localparam logic HDR_EN = 1'b0;
   assign hdr_word = '0;
`endif
   assign avail = fifo_rdfull ? {1'b1, {USEDW_W{1'b0}}} : {1'b0, fifo_rdusedw};
   assign xfer = src_valid & src_ready;
   // A beat leaving this cycle frees its slot, which keeps 1 beat/cycle with only 2 slots.
   assign used = occ + {1'b0, inflight_q} - {1'b0, xfer};
   assign fifo_rdreq = state_q == PKT && req_cnt_q < PW && used < 2'd2;
   assign push = inflight_q | (state_q == HDR);
   assign push_data = inflight_q ? fifo_q : hdr_word;
   assign push_sop = inflight_q ? fl_sop_q : 1'b1;
   assign push_eop = inflight_q & fl_eop_q;
   assign src_empty = 3'd0;
   always_comb begin
      state_d = state_q;
      req_cnt_d = state_q == IDLE ? '0 : req_cnt_q + (USEDW_W+1)'(fifo_rdreq);
      if (state_q == IDLE && cfg_enable && avail >= PW) state_d = FIRST;
      else if (state_q == HDR) state_d = PKT;
      else if (state_q == PKT && xfer && src_eop) state_d = IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         req_cnt_q    <= '0;
         inflight_q   <= 1'b0;
         fl_sop_q     <= 1'b0;
         fl_eop_q     <= 1'b0;
         pkt_count    <= '0;
         underrun_err <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_cnt_q    <= req_cnt_d;
         inflight_q   <= fifo_rdreq;
         fl_sop_q     <= !HDR_EN && req_cnt_q == '0;
         fl_eop_q     <= req_cnt_q == LAST;
         pkt_count    <= pkt_count + 32'(xfer & src_eop);
         underrun_err <= underrun_err | (fifo_rdreq & fifo_rdempty);
      end
   end
   myfifo_rd_skid #(.W(DATA_W + 2)) u_skid (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .push_data_i ({push_data, push_sop, push_eop}),
      .pop_i       (src_ready),
      .valid_o     (src_valid),
      .data_o      (out_bus),
      .occ_o       (occ)
   );
   assign {src_data, src_sop, src_eop} = out_bus;
endmodule

// File: tb/tb_myfifo_pkt_reader.sv
// tb_myfifo_pkt_reader: two readers (4-word and 256-word packets) fed by behavioural FIFOs.
module tb_myfifo_pkt_reader;
`ifdef PKT_HDR_EN
   localparam bit HDR = 1'b1;
`else
   localparam bit HDR = 1'b0;
`endif
   logic clk = 1'b0, reset, cfg_enable, ready, flush;
   always #5 clk = ~clk;
   logic [63:0] a_q, a_data, b_q, b_data;
   logic [7:0] a_used, b_used;
   logic a_full, a_empty, a_rdreq, a_valid, a_sop, a_eop, a_und;
   logic b_full, b_empty, b_rdreq, b_valid, b_sop, b_eop, b_und;
   logic [2:0] a_emp, b_emp;
   logic [31:0] a_cnt, b_cnt;
   logic [63:0] mem_a [4096], mem_b [4096];
   int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0, pos_a = 0, pos_b = 0;
   logic [15:0] seq_a = 0, seq_b = 0;
   logic [65:0] exp_a[$], exp_b[$];
   logic seen_a, seen_b;
   int total = 0, bad = 0;

   myfifo_pkt_reader #(.PKT_WORDS(4)) u_a (
      .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .fifo_q(a_q), .fifo_rdusedw(a_used),
      .fifo_rdfull(a_full), .fifo_rdempty(a_empty), .fifo_rdreq(a_rdreq), .src_data(a_data),
      .src_valid(a_valid), .src_ready(ready), .src_sop(a_sop), .src_eop(a_eop), .src_empty(a_emp),
      .pkt_count(a_cnt), .underrun_err(a_und));
   myfifo_pkt_reader #(.PKT_WORDS(256)) u_b (
      .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .fifo_q(b_q), .fifo_rdusedw(b_used),
      .fifo_rdfull(b_full), .fifo_rdempty(b_empty), .fifo_rdreq(b_rdreq), .src_data(b_data),
      .src_valid(b_valid), .src_ready(ready), .src_sop(b_sop), .src_eop(b_eop), .src_empty(b_emp),
      .pkt_count(b_cnt), .underrun_err(b_und));

   // Behavioural FIFOs: show-ahead-free, data one cycle after rdreq, full reports usedw=0.
   assign a_used = 8'(wr_a - rd_a);
   assign a_full = (wr_a - rd_a) == 256;
   assign a_empty = wr_a == rd_a;
   assign b_used = 8'(wr_b - rd_b);
   assign b_full = (wr_b - rd_b) == 256;
   assign b_empty = wr_b == rd_b;
   always @(posedge clk) begin
      if (flush) begin
         rd_a <= wr_a;
         rd_b <= wr_b;
      end else begin
         if (a_rdreq && rd_a != wr_a) begin
            a_q <= mem_a[rd_a % 4096];
            rd_a <= rd_a + 1;
         end
         if (b_rdreq && rd_b != wr_b) begin
            b_q <= mem_b[rd_b % 4096];
            rd_b <= rd_b + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic push_a(input logic [63:0] d);
      if (HDR && pos_a % 4 == 0) begin
         exp_a.push_back({16'hA5A5, seq_a, 16'd4, 16'h0000, 2'b10});
         seq_a++;
      end
      exp_a.push_back({d, !HDR && pos_a % 4 == 0, pos_a % 4 == 3});
      mem_a[wr_a % 4096] = d;
      wr_a++;
      pos_a++;
   endtask

   task automatic push_b(input logic [63:0] d);
      if (HDR && pos_b % 256 == 0) begin
         exp_b.push_back({16'hA5A5, seq_b, 16'd256, 16'h0000, 2'b10});
         seq_b++;
      end
      exp_b.push_back({d, !HDR && pos_b % 256 == 0, pos_b % 256 == 255});
      mem_b[wr_b % 4096] = d;
      wr_b++;
      pos_b++;
   endtask

   // Check any accepted beat at the falling edge, then advance to just after the next rising edge.
   task automatic tick();
      @(negedge clk);
      seen_a |= a_rdreq | a_valid;
      seen_b |= b_rdreq | b_valid;
      if (!reset && a_valid && ready) begin
         total++;
         assert (exp_a.size() > 0) else begin
            bad++;
            $error("FAIL a_extra_beat got=%h exp=none", {a_data, a_sop, a_eop});
         end
         if (exp_a.size() > 0) chk("a_beat", 80'({a_data, a_sop, a_eop}), 80'(exp_a.pop_front()));
      end
      if (!reset && b_valid && ready) begin
         total++;
         assert (exp_b.size() > 0) else begin
            bad++;
            $error("FAIL b_extra_beat got=%h exp=none", {b_data, b_sop, b_eop});
         end
         if (exp_b.size() > 0) chk("b_beat", 80'({b_data, b_sop, b_eop}), 80'(exp_b.pop_front()));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag, input int budget, output int n);
      n = 0;
      while ((exp_a.size() != 0 || exp_b.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 80'(exp_a.size() + exp_b.size()), 80'(0));
   endtask

   initial begin
      int n, sent;
      reset = 1'b1;
      cfg_enable = 1'b0;
      ready = 1'b0;
      flush = 1'b0;
      seen_a = 1'b0;
      seen_b = 1'b0;
      repeat (3) tick();
      chk("rst_a_out", 80'({a_rdreq, a_valid, a_sop, a_eop, a_emp, a_und, a_data}), 80'(0));
      chk("rst_b_out", 80'({b_rdreq, b_valid, b_sop, b_eop, b_emp, b_und, b_data}), 80'(0));
      chk("rst_cnt", 80'({a_cnt, b_cnt}), 80'(0));
      reset = 1'b0;
      // 1: one packet, ready held high: fixed latency and 1 beat/cycle
      for (int i = 1; i <= 4; i++) push_a(64'(i));
      cfg_enable = 1'b1;
      ready = 1'b1;
      drain("t1_drain", 50, n);
      chk("t1_cycles", 80'(n), 80'(HDR ? 8 : 7));
      chk("t1_pkt_count", 80'(a_cnt), 80'(1));
      // 2: partial packet must not start
      for (int i = 5; i <= 7; i++) push_a(64'(i));
      seen_a = 1'b0;
      repeat (10) tick();
      chk("t2_no_start", 80'(seen_a), 80'(0));
      push_a(64'd8);
      drain("t2_drain", 50, n);
      chk("t2_pkt_count", 80'(a_cnt), 80'(2));
      // 3: 1000 packets under random backpressure
      sent = 0;
      n = 0;
      while ((sent < 4000 || exp_a.size() != 0) && n < 60000) begin
         ready = 1'($urandom_range(0, 1));
         if (sent < 4000 && wr_a - rd_a < 256) begin
            push_a({$urandom, $urandom});
            sent++;
         end
         tick();
         n++;
      end
      ready = 1'b1;
      chk("t3_drain", 80'(exp_a.size()), 80'(0));
      chk("t3_pkt_count", 80'(a_cnt), 80'(1002));
      chk("t3_underrun", 80'(a_und), 80'(0));
      // 4: 256-word packet only starts once the FIFO reports full
      for (int i = 0; i < 255; i++) push_b({32'hB0B0_0000, 32'(i)});
      seen_b = 1'b0;
      repeat (8) tick();
      chk("t4_no_start", 80'(seen_b), 80'(0));
      push_b({32'hB0B0_0000, 32'(255)});
      drain("t4_drain", 700, n);
      chk("t4_pkt_count", 80'(b_cnt), 80'(1));
      chk("t4_underrun", 80'(b_und), 80'(0));
      // 5: reset mid-packet, then 3 clean packets (header seq restarts at 0)
      for (int i = 0; i < 4; i++) push_a(64'hC000 + 64'(i));
      n = 0;
      while (exp_a.size() > (HDR ? 3 : 2) && n < 50) begin
         tick();
         n++;
      end
      chk("t5_mid_packet", 80'(exp_a.size()), 80'(HDR ? 3 : 2));
      reset = 1'b1;
      cfg_enable = 1'b0;
      tick();
      chk("t5_rst_out", 80'({a_rdreq, a_valid, a_sop, a_eop, a_emp, a_und, a_data}), 80'(0));
      chk("t5_rst_cnt", 80'(a_cnt), 80'(0));
      reset = 1'b0;
      flush = 1'b1;
      exp_a.delete();
      pos_a = 0;
      seq_a = 0;
      seq_b = 0;
      tick();
      flush = 1'b0;
      for (int i = 0; i < 12; i++) push_a(64'hD000 + 64'(i));
      cfg_enable = 1'b1;
      drain("t5_drain", 100, n);
      chk("t5_pkt_count", 80'(a_cnt), 80'(3));
      chk("end_underrun", 80'({a_und, b_und}), 80'(0));
      chk("end_empty", 80'({a_emp, b_emp}), 80'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
